// File: rtl/regfile_core.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_core
//  Purpose  : 32 x DATA_BITS general-purpose register file for the MIPS
//             datapath. Two combinational read ports with write-through
//             bypass, one synchronous write port, and a sequential debug
//             scan engine that streams every register out in index order.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          system clock, rising edge
//    rst        in   1          asynchronous active-high reset
//    IR1, IR2   in   5          read indices (rs / rt)
//    W          in   5          write index
//    WE         in   1          write enable
//    Din        in   DATA_BITS  write data
//    R1, R2     out  DATA_BITS  read data (combinational, bypassed)
//    dbg_start  in   1          request a full register scan
//    dbg_busy   out  1          scan in progress (SCAN or DONE)
//    dbg_valid  out  1          dbg_index/dbg_data hold a scanned entry
//    dbg_index  out  5          index of the scanned entry
//    dbg_data   out  DATA_BITS  value of the scanned entry
//    dbg_done   out  1          one-cycle pulse after the last entry
// ============================================================================
module regfile_core #(
  parameter int DATA_BITS = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           IR1,
  input  logic [4:0]           IR2,
  input  logic [4:0]           W,
  input  logic                 WE,
  input  logic [DATA_BITS-1:0] Din,
  output logic [DATA_BITS-1:0] R1,
  output logic [DATA_BITS-1:0] R2,
  input  logic                 dbg_start,
  output logic                 dbg_busy,
  output logic                 dbg_valid,
  output logic [4:0]           dbg_index,
  output logic [DATA_BITS-1:0] dbg_data,
  output logic                 dbg_done
);

  localparam logic [4:0] LAST_IDX = 5'(REG_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Register array
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] regs_q [REG_COUNT];

  // Writes to $0 are dropped here, so entry 0 holds its reset value of zero
  // forever and every read of index 0 naturally returns 0.
  logic wr_en;
  assign wr_en = WE && (W != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[W] <= Din;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports with write-through bypass. wr_en already excludes W==0, so
  // index 0 is never forwarded.
  // --------------------------------------------------------------------------
  assign R1 = (wr_en && (IR1 == W)) ? Din : regs_q[IR1];
  assign R2 = (wr_en && (IR2 == W)) ? Din : regs_q[IR2];

  // --------------------------------------------------------------------------
  // Debug scan engine
  // --------------------------------------------------------------------------
  state_t               state_q;
  logic                 dbg_busy_q;
  logic                 dbg_valid_q;
  logic [4:0]           dbg_index_q;
  logic [DATA_BITS-1:0] dbg_data_q;
  logic                 dbg_done_q;

  // Index that will be on display after the coming edge, and its data.
  // The outputs are registered, so the value loaded must already include a
  // write that commits on that same edge; that is why Din is forwarded here
  // when the write targets the slot about to be shown.
  logic [4:0]           scan_idx_d;
  logic [DATA_BITS-1:0] scan_data_d;

  assign scan_idx_d  = (state_q == S_SCAN) ? (dbg_index_q + 5'd1) : 5'd0;
  assign scan_data_d = (wr_en && (W == scan_idx_d)) ? Din : regs_q[scan_idx_d];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dbg_busy_q  <= 1'b0;
      dbg_valid_q <= 1'b0;
      dbg_index_q <= 5'd0;
      dbg_data_q  <= '0;
      dbg_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dbg_done_q <= 1'b0;
          if (dbg_start) begin
            state_q     <= S_SCAN;
            dbg_busy_q  <= 1'b1;
            dbg_valid_q <= 1'b1;
            dbg_index_q <= 5'd0;
            dbg_data_q  <= scan_data_d;
          end else begin
            dbg_busy_q  <= 1'b0;
            dbg_valid_q <= 1'b0;
          end
        end

        // dbg_start is not looked at here or in S_DONE: a request while
        // busy is simply dropped.
        S_SCAN: begin
          if (dbg_index_q == LAST_IDX) begin
            state_q     <= S_DONE;
            dbg_valid_q <= 1'b0;
            dbg_done_q  <= 1'b1;
            dbg_index_q <= 5'd0;
            dbg_data_q  <= '0;
          end else begin
            dbg_index_q <= scan_idx_d;
            dbg_data_q  <= scan_data_d;
          end
        end

        S_DONE: begin
          state_q    <= S_IDLE;
          dbg_done_q <= 1'b0;
          dbg_busy_q <= 1'b0;
        end

        default: begin
          state_q     <= S_IDLE;
          dbg_busy_q  <= 1'b0;
          dbg_valid_q <= 1'b0;
          dbg_index_q <= 5'd0;
          dbg_data_q  <= '0;
          dbg_done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_busy  = dbg_busy_q;
  assign dbg_valid = dbg_valid_q;
  assign dbg_index = dbg_index_q;
  assign dbg_data  = dbg_data_q;
  assign dbg_done  = dbg_done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_core
//  Purpose  : Self-checking bench for regfile_core. A plain array holds the
//             expected register contents; each accepted scan request queues
//             the 32 entries plus a done marker, and a negedge monitor pops
//             one item per cycle and compares it with the debug outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  IR1 = '0, IR2 = '0, W = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] R1, R2;
  logic        dbg_start = 1'b0;
  logic        dbg_busy, dbg_valid, dbg_done;
  logic [4:0]  dbg_index;
  logic [31:0] dbg_data;

  regfile_core #(.DATA_BITS(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst),
    .IR1(IR1), .IR2(IR2), .W(W), .WE(WE), .Din(Din),
    .R1(R1), .R2(R2),
    .dbg_start(dbg_start), .dbg_busy(dbg_busy), .dbg_valid(dbg_valid),
    .dbg_index(dbg_index), .dbg_data(dbg_data), .dbg_done(dbg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done;
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sq[$];
  logic [31:0] model [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          next_ok = 0;   // first edge count at which a new start is accepted

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] ir, input logic we,
                                           input logic [4:0] w, input logic [31:0] din);
    if (we && w != 5'd0 && ir == w) return din;
    if (ir == 5'd0) return 32'd0;
    return model[ir];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    sq.delete();
    next_ok = 0;
  endtask

  // One clock cycle: drive inputs, check the read ports, then take the edge
  // and advance the reference model. Called at posedge+1.
  task automatic drive_cycle(input logic we, input logic [4:0] w, input logic [31:0] din,
                             input logic [4:0] ir1, input logic [4:0] ir2, input logic start);
    WE = we; W = w; Din = din; IR1 = ir1; IR2 = ir2; dbg_start = start;
    #2;
    if (!rst) begin
      check("R1", R1, exp_read(ir1, we, w, din));
      check("R2", R2, exp_read(ir2, we, w, din));
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      if (we && w != 5'd0) begin
        model[w] = din;
        // Entries still waiting for their slot will show the new value.
        foreach (sq[i]) if (!sq[i].done && sq[i].idx == w) sq[i].data = din;
      end
      if (start && cyc >= next_ok) begin
        for (int k = 0; k < 32; k++) sq.push_back('{1'b0, 5'(k), (k == 0) ? 32'd0 : model[k]});
        sq.push_back('{1'b1, 5'd0, 32'd0});
        next_ok = cyc + 34;
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
  endtask

  task automatic wait_index(input logic [4:0] n);
    bit hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (dbg_valid && dbg_index == n) hit = 1;
      else idle_cycle();
    end
    check("wait_index", 32'(hit), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sq.size() != 0; k++) idle_cycle();
    check("drain", 32'(sq.size()), 32'd0);
  endtask

  // Lock-step monitor: while the queue holds items, the DUT must present
  // exactly the front item this cycle; otherwise nothing at all.
  always @(negedge clk) begin
    exp_t e;
    check("dbg_busy", 32'(dbg_busy), 32'(sq.size() != 0));
    if (sq.size() != 0) begin
      e = sq.pop_front();
      if (e.done) begin
        check("dbg_done", 32'(dbg_done), 32'd1);
        check("dbg_valid_at_done", 32'(dbg_valid), 32'd0);
      end else begin
        check("dbg_valid", 32'(dbg_valid), 32'd1);
        check("dbg_index", 32'(dbg_index), 32'(e.idx));
        check("dbg_data", dbg_data, e.data);
        check("dbg_done_in_scan", 32'(dbg_done), 32'd0);
      end
    end else begin
      check("idle_valid", 32'(dbg_valid), 32'd0);
      check("idle_done", 32'(dbg_done), 32'd0);
    end
  end

  initial begin
    logic        we, st;
    logic [4:0]  w, a, b;
    logic [31:0] d;

    model_clear();
    // Reset held across two edges, released at posedge+1.
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", 32'(dbg_busy), 32'd0);
    check("rst_index", 32'(dbg_index), 32'd0);
    check("rst_data", dbg_data, 32'd0);
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b0);

    // Write / read and $0 protection.
    drive_cycle(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd1, 1'b0);
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b0);
    drive_cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);

    // Bypass on both ports, then the committed value; bypass never to $0.
    drive_cycle(1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 1'b0);
    drive_cycle(1'b1, 5'd9, 32'hCAFE0000, 5'd9, 5'd9, 1'b0);
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0);
    drive_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd9, 1'b0);

    // Full scan over reg[k] = k*4.
    for (int k = 1; k < 32; k++) drive_cycle(1'b1, 5'(k), 32'(k * 4), 5'(k), 5'(k - 1), 1'b0);
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1);
    drain();

    // Write ahead of the scan slot plus an ignored start while busy.
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    wait_index(5'd3);
    drive_cycle(1'b1, 5'd20, 32'hAAAA5555, 5'd20, 5'd2, 1'b1);
    drive_cycle(1'b1, 5'd2, 32'h22222222, 5'd2, 5'd20, 1'b0);
    drain();

    // Randomized traffic with occasional start pulses.
    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom_range(0, 1));
      w  = 5'($urandom_range(0, 31));
      d  = $urandom;
      a  = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      b  = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      st = ($urandom_range(0, 15) == 0);
      drive_cycle(we, w, d, a, b, st);
    end

    // Start held high: back-to-back scans with writes in flight.
    for (int k = 0; k < 80; k++) begin
      drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
    end
    drain();

    // Reset in the middle of a scan.
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    wait_index(5'd10);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(dbg_valid), 32'd0);
    check("midrst_busy", 32'(dbg_busy), 32'd0);
    check("midrst_done", 32'(dbg_done), 32'd0);
    check("midrst_index", 32'(dbg_index), 32'd0);
    model_clear();
    #2;
    @(posedge clk); #1;
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    rst = 1'b0;
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, 1'b0);
    drive_cycle(1'b0, 5'd0, 32'd0, 5'd9, 5'd31, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
